// File: rtl/mem_dados_wbuf.sv
// MEM-stage data memory: single-port word RAM behind a DEPTH-entry store buffer.
// Define MEM_DADOS_FWD_EN to forward buffered stores to loads instead of stalling them.
module mem_dados_wbuf #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      wdata,
    output logic                   ready,
    output logic                   rvalid,
    output logic [DATA_W-1:0]      rdata,
    output logic [$clog2(DEPTH):0] wbuf_count,
    output logic                   idle
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] ba_q [DEPTH];
    logic [DATA_W-1:0] bd_q [DEPTH];
    logic [DATA_W-1:0] mem  [2**ADDR_W];

    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              full;
    logic              hit;
    logic [PW-1:0]     slot;
    logic              acc;
    logic              st;
    logic              ld;
    logic              drain;
`ifdef MEM_DADOS_FWD_EN
    logic [DATA_W-1:0] hit_data;
`endif

    assign full = (count_q == CW'(DEPTH));

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        hit  = 1'b0;
        slot = '0;
`ifdef MEM_DADOS_FWD_EN
        hit_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            slot = head_q + PW'(i);
            if (CW'(i) < count_q && ba_q[slot] == addr) begin
                hit = 1'b1;
`ifdef MEM_DADOS_FWD_EN
                hit_data = bd_q[slot];
`endif
            end
        end
    end

    always_comb begin
        ready = 1'b1;
        if (we) begin
            ready = !full;
        end else begin
`ifdef MEM_DADOS_FWD_EN
            ready = 1'b1;
`else
            ready = !hit;
`endif
        end
    end

    assign acc   = req && ready;
    assign st    = acc && we;
    assign ld    = acc && !we;
    assign drain = !acc && (count_q != '0);

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        rvalid_d = ld;
        rdata_d  = rdata_q;
        if (st) begin
            tail_d  = tail_q + 1'b1;
            count_d = count_q + 1'b1;
        end else if (drain) begin
            head_d  = head_q + 1'b1;
            count_d = count_q - 1'b1;
        end
        if (ld) begin
`ifdef MEM_DADOS_FWD_EN
            rdata_d = hit ? hit_data : mem[addr];
`else
            rdata_d = mem[addr];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage arrays carry no reset; occupancy is defined by the pointers.
    always_ff @(posedge clk) begin
        if (st) begin
            ba_q[tail_q] <= addr;
            bd_q[tail_q] <= wdata;
        end
        if (drain) begin
            mem[ba_q[head_q]] <= bd_q[head_q];
        end
    end

    assign rvalid     = rvalid_q;
    assign rdata      = rdata_q;
    assign wbuf_count = count_q;
    assign idle       = (count_q == '0) && !rvalid_q;

endmodule
